// File: rtl/ss_apb_gpio_pkg.sv
// -----------------------------------------------------------------------------
// ss_apb_gpio_pkg
// Shared definitions for the APB GPIO subsystem block: register index enum
// (decoded from PADDR[4:2]), byte offsets of each register, and the ID word.
// -----------------------------------------------------------------------------
package ss_apb_gpio_pkg;

  // Register index as seen on PADDR[4:2].
  typedef enum logic [2:0] {
    REG_DOUT    = 3'd0,
    REG_DIR     = 3'd1,
    REG_DIN     = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_STATUS  = 3'd5,
    REG_ID      = 3'd6,
    REG_RSVD    = 3'd7
  } reg_idx_e;

  // Byte offsets of the mapped registers.
  localparam logic [31:0] OFF_DOUT    = 32'h00;
  localparam logic [31:0] OFF_DIR     = 32'h04;
  localparam logic [31:0] OFF_DIN     = 32'h08;
  localparam logic [31:0] OFF_RISE_EN = 32'h0C;
  localparam logic [31:0] OFF_FALL_EN = 32'h10;
  localparam logic [31:0] OFF_STATUS  = 32'h14;
  localparam logic [31:0] OFF_ID      = 32'h18;

  // Upper half of the ID word; the low bits carry the GPIO width.
  localparam logic [31:0] ID_BASE = 32'h6770_0000;

  function automatic logic [31:0] id_value(input int unsigned gpio_w);
    return ID_BASE | 32'(gpio_w);
  endfunction

endpackage

// File: rtl/ss_gpio_sync.sv
// -----------------------------------------------------------------------------
// ss_gpio_sync
// Multi-flop synchroniser for asynchronous GPIO inputs. Each bit passes
// through STAGES flops; all stages clear on reset.
//   clk_in    : clock
//   reset_int : synchronous active-high reset
//   i_d       : asynchronous input bus (WIDTH)
//   o_q       : synchronised output (last stage)
// -----------------------------------------------------------------------------
module ss_gpio_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_int,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // NOTE: non-blocking (<=) on every flop, so each stage samples the value its
  // predecessor held before this edge; blocking would collapse the chain.
  // NOTE: the stage array is a handful of flops, not RAM, so it is reset like
  // any register and DIN reads a defined 0 straight after reset.
  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/ss_apb_gpio.sv
// -----------------------------------------------------------------------------
// ss_apb_gpio
// APB3 slave GPIO block with output drive, direction control, synchronised
// inputs, per-bit rising/falling edge capture into a W1C STATUS register and
// a level interrupt.
//   clk_in, reset_int        : clock, synchronous active-high reset
//   PADDR..PWRITE            : APB request (zero-wait-state slave)
//   PRDATA, PREADY, PSLVERR  : APB response, combinational in the access cycle
//   irq_3 / irq_en_3         : registered interrupt / SoC-side mask
//   ss_ctrl_3                : bit0 = subsystem enable, other bits unused
//   pmod_gpi/gpo/gpio_oe     : pad input, pad output value, pad output enable
// Register map on PADDR[4:2]: DOUT, DIR, DIN, RISE_EN, FALL_EN, STATUS, ID.
// -----------------------------------------------------------------------------
module ss_apb_gpio
  import ss_apb_gpio_pkg::*;
#(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              reset_int,
  input  logic [31:0]       PADDR,
  input  logic              PENABLE,
  input  logic              PSEL,
  input  logic [31:0]       PWDATA,
  input  logic              PWRITE,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              irq_3,
  input  logic              irq_en_3,
  input  logic [7:0]        ss_ctrl_3,
  input  logic [GPIO_W-1:0] pmod_gpi,
  output logic [GPIO_W-1:0] pmod_gpo,
  output logic [GPIO_W-1:0] pmod_gpio_oe
);

  // ---------------------------------------------------------------- state
  logic [GPIO_W-1:0] r_dout;
  logic [GPIO_W-1:0] r_dir;
  logic [GPIO_W-1:0] r_rise_en;
  logic [GPIO_W-1:0] r_fall_en;
  logic [GPIO_W-1:0] r_status;
  logic [GPIO_W-1:0] r_prev;
  logic              r_irq;

  // ---------------------------------------------------------------- wires
  logic              w_enable;
  reg_idx_e          w_off;
  logic              w_access;
  logic              w_bad_addr;
  logic              w_bad_write;
  logic              w_err;
  logic              w_wr;
  logic              w_rd;
  logic [GPIO_W-1:0] w_wdata;
  logic [GPIO_W-1:0] w_din;
  logic [GPIO_W-1:0] w_rise;
  logic [GPIO_W-1:0] w_fall;
  logic [GPIO_W-1:0] w_edge_set;
  logic [GPIO_W-1:0] w_w1c;
  logic              w_irq_next;
  logic [31:0]       w_rdata_sel;
  logic              w_unused;

  // Address bits above the register window, PWDATA bits above GPIO_W and the
  // spare control bits carry no meaning here.
  assign w_unused = ^{PADDR[31:5], PWDATA, ss_ctrl_3[7:1]};

  assign w_enable = ss_ctrl_3[0];
  assign w_off    = reg_idx_e'(PADDR[4:2]);
  assign w_wdata  = PWDATA[GPIO_W-1:0];

  // ---------------------------------------------------------------- input sync
  ss_gpio_sync #(
    .WIDTH  (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in    (clk_in),
    .reset_int (reset_int),
    .i_d       (pmod_gpi),
    .o_q       (w_din)
  );

  // ---------------------------------------------------------------- APB decode
  // Reset masks the access so a transfer caught by reset neither completes
  // nor writes anything.
  assign w_access    = PSEL & PENABLE & ~reset_int;
  assign w_bad_addr  = (PADDR[1:0] != 2'b00) | (w_off == REG_RSVD);
  assign w_bad_write = PWRITE & ((w_off == REG_DIN) | (w_off == REG_ID));
  assign w_err       = ~w_enable | w_bad_addr | w_bad_write;
  assign w_wr        = w_access &  PWRITE & ~w_err;
  assign w_rd        = w_access & ~PWRITE & ~w_err;

  assign PREADY  = w_access;
  assign PSLVERR = w_access & w_err;

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rdata_sel = '0;
    case (w_off)
      REG_DOUT:    w_rdata_sel = 32'(r_dout);
      REG_DIR:     w_rdata_sel = 32'(r_dir);
      REG_DIN:     w_rdata_sel = 32'(w_din);
      REG_RISE_EN: w_rdata_sel = 32'(r_rise_en);
      REG_FALL_EN: w_rdata_sel = 32'(r_fall_en);
      REG_STATUS:  w_rdata_sel = 32'(r_status);
      REG_ID:      w_rdata_sel = id_value(GPIO_W);
      default:     w_rdata_sel = '0;
    endcase
  end

  assign PRDATA = w_rd ? w_rdata_sel : 32'h0;

  // ---------------------------------------------------------------- edges
  // r_prev follows DIN even while disabled, so re-enabling sees no stale edge.
  assign w_rise     = w_din & ~r_prev;
  assign w_fall     = ~w_din & r_prev;
  assign w_edge_set = w_enable ? ((w_rise & r_rise_en) | (w_fall & r_fall_en))
                               : '0;
  assign w_w1c      = (w_wr && (w_off == REG_STATUS)) ? w_wdata : '0;
  assign w_irq_next = irq_en_3 & w_enable & (|(r_status & (r_rise_en | r_fall_en)));

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      r_dout    <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
      r_prev    <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr) begin
        case (w_off)
          REG_DOUT:    r_dout    <= w_wdata;
          REG_DIR:     r_dir     <= w_wdata;
          REG_RISE_EN: r_rise_en <= w_wdata;
          REG_FALL_EN: r_fall_en <= w_wdata;
          default:     ;
        endcase
      end
      // Clear first, then OR in new edges: a coincident edge keeps its bit.
      r_status <= (r_status & ~w_w1c) | w_edge_set;
      r_prev   <= w_din;
      r_irq    <= w_irq_next;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign irq_3        = r_irq;
  assign pmod_gpo     = w_enable ? (r_dout & r_dir) : '0;
  assign pmod_gpio_oe = w_enable ? r_dir : '0;

endmodule

// File: tb/tb_ss_apb_gpio.sv
// -----------------------------------------------------------------------------
// tb_ss_apb_gpio
// Self-checking bench for ss_apb_gpio. A 16-bit instance is compared every
// cycle against a behavioural model (synchroniser as a delay queue, edges as
// bit arithmetic); a directed table plus hand sequences cover latency, the
// set-vs-clear collision and reset mid-transfer. An 8-bit instance shares
// the bus to cover width truncation.
// -----------------------------------------------------------------------------
module tb_ss_apb_gpio;
  import ss_apb_gpio_pkg::*;

  localparam int S = 2;

  logic        clk_in = 1'b0;
  logic        reset_int;
  logic [31:0] PADDR;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        irq_en_3;
  logic [7:0]  ss_ctrl_3;
  logic [15:0] pmod_gpi;

  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, irq_3;
  logic [15:0] pmod_gpo, pmod_gpio_oe;

  logic [31:0] prdata8;
  logic        pready8, pslverr8, irq8;
  logic [7:0]  gpo8, oe8;

  always #5 clk_in = ~clk_in;

  ss_apb_gpio #(.GPIO_W(16), .SYNC_STAGES(S)) u_dut (
    .clk_in(clk_in), .reset_int(reset_int),
    .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .irq_3(irq_3), .irq_en_3(irq_en_3), .ss_ctrl_3(ss_ctrl_3),
    .pmod_gpi(pmod_gpi), .pmod_gpo(pmod_gpo), .pmod_gpio_oe(pmod_gpio_oe)
  );

  ss_apb_gpio #(.GPIO_W(8), .SYNC_STAGES(S)) u_dut8 (
    .clk_in(clk_in), .reset_int(reset_int),
    .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8),
    .irq_3(irq8), .irq_en_3(irq_en_3), .ss_ctrl_3(ss_ctrl_3),
    .pmod_gpi(pmod_gpi[7:0]), .pmod_gpo(gpo8), .pmod_gpio_oe(oe8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic [15:0] m_dout, m_dir, m_rise, m_fall, m_status, m_prev, m_din;
  logic        m_irq;
  logic [15:0] m_q[$];   // last S input samples; front is what DIN shows
  logic        model_on = 1'b0;

  function automatic logic m_err();
    logic [2:0] off;
    off = PADDR[4:2];
    return !ss_ctrl_3[0] || (PADDR[1:0] != 2'b00) || (off == 3'd7) ||
           (PWRITE && (off == 3'd2 || off == 3'd6));
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0:    return {16'h0, m_dout};
      3'd1:    return {16'h0, m_dir};
      3'd2:    return {16'h0, m_din};
      3'd3:    return {16'h0, m_rise};
      3'd4:    return {16'h0, m_fall};
      3'd5:    return {16'h0, m_status};
      3'd6:    return 32'h6770_0010;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk_in) begin : model
    logic [15:0] set_bits, w1c;
    logic        irq_next;
    if (reset_int) begin
      m_dout = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
      m_prev = '0; m_irq = 1'b0; m_din = '0;
      m_q.delete();
      for (int i = 0; i < S; i++) m_q.push_back(16'h0);
    end else begin
      set_bits = ss_ctrl_3[0] ? ((m_din & ~m_prev & m_rise) | (~m_din & m_prev & m_fall)) : 16'h0;
      irq_next = irq_en_3 && ss_ctrl_3[0] && ((m_status & (m_rise | m_fall)) != 16'h0);
      w1c = 16'h0;
      if (PSEL && PENABLE && PWRITE && !m_err()) begin
        case (PADDR[4:2])
          3'd0: m_dout = PWDATA[15:0];
          3'd1: m_dir  = PWDATA[15:0];
          3'd3: m_rise = PWDATA[15:0];
          3'd4: m_fall = PWDATA[15:0];
          3'd5: w1c    = PWDATA[15:0];
          default: ;
        endcase
      end
      m_status = (m_status & ~w1c) | set_bits;
      m_irq    = irq_next;
      m_prev   = m_din;
      m_q.push_back(pmod_gpi);
      void'(m_q.pop_front());
      m_din = m_q[0];
    end
  end

  // Cycle-by-cycle comparison of every 16-bit instance output.
  logic c_acc, c_err;
  always @(negedge clk_in) begin
    if (model_on) begin
      #1;
      c_acc = PSEL && PENABLE && !reset_int;
      c_err = m_err();
      check("pready",  32'(PREADY),  32'(c_acc));
      check("pslverr", 32'(PSLVERR), 32'(c_acc && c_err));
      check("prdata",  PRDATA, (c_acc && !PWRITE && !c_err) ? m_read(PADDR[4:2]) : 32'h0);
      check("irq",     32'(irq_3), 32'(m_irq));
      check("gpo",     32'(pmod_gpo),     ss_ctrl_3[0] ? 32'(m_dout & m_dir) : 32'h0);
      check("gpio_oe", 32'(pmod_gpio_oe), ss_ctrl_3[0] ? 32'(m_dir) : 32'h0);
    end
  end

  // ------------------------------------------------------------ APB driver
  task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic [31:0] rdata8, output logic err);
    @(negedge clk_in);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    @(negedge clk_in);
    PENABLE = 1'b1;
    #1;
    rdata = PRDATA; rdata8 = prdata8; err = PSLVERR;
    @(posedge clk_in);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_gpo;
    logic [15:0] exp_oe;
  } vec_t;

  vec_t vecs[16];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] rd, rd8;
    logic        er;
    int          st_cyc, irq_cyc;
    logic [2:0]  off;
    logic [1:0]  low;

    vecs[0]  = '{8'h01, OFF_DIR,     1'b1, 32'h0000_00FF, 32'h0,         1'b0, 16'h0000, 16'h00FF};
    vecs[1]  = '{8'h01, OFF_DOUT,    1'b1, 32'h0000_A5A5, 32'h0,         1'b0, 16'h00A5, 16'h00FF};
    vecs[2]  = '{8'h01, OFF_DOUT,    1'b0, 32'h0,         32'h0000_A5A5, 1'b0, 16'h00A5, 16'h00FF};
    vecs[3]  = '{8'h01, OFF_DIR,     1'b0, 32'h0,         32'h0000_00FF, 1'b0, 16'h00A5, 16'h00FF};
    vecs[4]  = '{8'h01, 32'h1C,      1'b0, 32'h0,         32'h0,         1'b1, 16'h00A5, 16'h00FF};
    vecs[5]  = '{8'h01, OFF_DIN,     1'b1, 32'h0000_FFFF, 32'h0,         1'b1, 16'h00A5, 16'h00FF};
    vecs[6]  = '{8'h01, 32'h02,      1'b0, 32'h0,         32'h0,         1'b1, 16'h00A5, 16'h00FF};
    vecs[7]  = '{8'h01, OFF_DIN,     1'b0, 32'h0,         32'h0000_3C3C, 1'b0, 16'h00A5, 16'h00FF};
    vecs[8]  = '{8'h01, OFF_ID,      1'b0, 32'h0,         32'h6770_0010, 1'b0, 16'h00A5, 16'h00FF};
    vecs[9]  = '{8'h00, OFF_DOUT,    1'b0, 32'h0,         32'h0,         1'b1, 16'h0000, 16'h0000};
    vecs[10] = '{8'h00, OFF_DOUT,    1'b1, 32'h0000_1234, 32'h0,         1'b1, 16'h0000, 16'h0000};
    vecs[11] = '{8'h01, OFF_DOUT,    1'b0, 32'h0,         32'h0000_A5A5, 1'b0, 16'h00A5, 16'h00FF};
    vecs[12] = '{8'h81, OFF_DOUT,    1'b1, 32'hFFFF_5A5A, 32'h0,         1'b0, 16'h005A, 16'h00FF};
    vecs[13] = '{8'h01, OFF_DOUT,    1'b0, 32'h0,         32'h0000_5A5A, 1'b0, 16'h005A, 16'h00FF};
    vecs[14] = '{8'h01, OFF_ID,      1'b1, 32'h0,         32'h0,         1'b1, 16'h005A, 16'h00FF};
    vecs[15] = '{8'h01, 32'h17,      1'b0, 32'h0,         32'h0,         1'b1, 16'h005A, 16'h00FF};

    reset_int = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; irq_en_3 = 1'b0; ss_ctrl_3 = 8'h01;
    pmod_gpi = 16'hFFFF;

    // ---- reset state, pmod_gpi held high through release
    @(posedge clk_in); #1; model_on = 1'b1;
    @(negedge clk_in); #2;
    check("rst_pready", 32'(PREADY), 32'h0);
    check("rst_irq",    32'(irq_3),  32'h0);
    check("rst_oe",     32'(pmod_gpio_oe), 32'h0);
    reset_int = 1'b0;
    repeat (S + 3) @(negedge clk_in);
    apb(OFF_STATUS, 1'b0, 32'h0, rd, rd8, er);
    check("post_rst_status", rd, 32'h0);
    check("post_rst_irq", 32'(irq_3), 32'h0);
    apb(OFF_DIN, 1'b0, 32'h0, rd, rd8, er);
    check("post_rst_din", rd, 32'h0000_FFFF);
    for (int i = 0; i < 4; i++) begin
      apb(32'(i) * 32'h4 + (i == 2 ? 32'h4 : 32'h0), 1'b0, 32'h0, rd, rd8, er);
      check($sformatf("post_rst_reg%0d", i), rd, 32'h0);
    end

    // ---- directed table
    pmod_gpi = 16'h3C3C;
    repeat (S + 2) @(negedge clk_in);
    for (int i = 0; i < 16; i++) begin
      ss_ctrl_3 = vecs[i].ctrl;
      apb(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, rd8, er);
      check($sformatf("vec%0d_rdata", i),  rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_slverr", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_gpo", i),    32'(pmod_gpo), 32'(vecs[i].exp_gpo));
      check($sformatf("vec%0d_oe", i),     32'(pmod_gpio_oe), 32'(vecs[i].exp_oe));
    end

    // ---- rising edge latency; cycle 1 is the cycle pmod_gpi changes in
    ss_ctrl_3 = 8'h01;
    irq_en_3  = 1'b1;
    apb(OFF_RISE_EN, 1'b1, 32'h1, rd, rd8, er);
    @(negedge clk_in);
    pmod_gpi[0] = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = OFF_STATUS;
    st_cyc = 0; irq_cyc = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) @(negedge clk_in);
      #1;
      if (st_cyc == 0 && PRDATA[0]) st_cyc = cyc;
      if (irq_cyc == 0 && irq_3) irq_cyc = cyc;
    end
    check("status_latency", 32'(st_cyc),  32'(S + 2));
    check("irq_latency",    32'(irq_cyc), 32'(S + 3));
    // W1C in the following access cycle; irq drops two cycles later.
    @(negedge clk_in);
    PWRITE = 1'b1; PWDATA = 32'h1;
    @(posedge clk_in); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge clk_in); #2;
    check("irq_after_w1c_1", 32'(irq_3), 32'h1);
    @(negedge clk_in); #2;
    check("irq_after_w1c_2", 32'(irq_3), 32'h0);
    apb(OFF_STATUS, 1'b0, 32'h0, rd, rd8, er);
    check("status_cleared", rd, 32'h0);

    // ---- falling edge on bit 15 colliding with W1C of the same bit
    apb(OFF_FALL_EN, 1'b1, 32'h8000, rd, rd8, er);
    @(negedge clk_in);
    pmod_gpi[15] = 1'b1;
    repeat (S + 3) @(negedge clk_in);
    pmod_gpi[15] = 1'b0;
    repeat (S) @(negedge clk_in);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = OFF_STATUS; PWDATA = 32'h8000;
    @(posedge clk_in); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    apb(OFF_STATUS, 1'b0, 32'h0, rd, rd8, er);
    check("set_wins_over_w1c", rd, 32'h0000_8000);
    apb(OFF_STATUS, 1'b1, 32'h8000, rd, rd8, er);
    apb(OFF_STATUS, 1'b0, 32'h0, rd, rd8, er);
    check("w1c_bit15", rd, 32'h0);

    // ---- reset asserted in the access phase of a DOUT write
    @(negedge clk_in);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = OFF_DOUT; PWDATA = 32'hFFFF;
    @(negedge clk_in);
    PENABLE = 1'b1; reset_int = 1'b1;
    #2;
    check("midrst_pready",   32'(PREADY),  32'h0);
    check("midrst_pslverr",  32'(PSLVERR), 32'h0);
    check("midrst_prdata",   PRDATA,       32'h0);
    check("midrst_pready8",  32'(pready8), 32'h0);
    @(posedge clk_in); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge clk_in);
    reset_int = 1'b0;
    apb(OFF_DOUT, 1'b0, 32'h0, rd, rd8, er);
    check("midrst_dout",  rd,  32'h0);
    check("midrst_dout8", rd8, 32'h0);
    apb(OFF_DOUT, 1'b1, 32'hFFFF, rd, rd8, er);
    apb(OFF_DOUT, 1'b0, 32'h0, rd, rd8, er);
    check("dout16_ffff", rd,  32'h0000_FFFF);
    check("dout8_ffff",  rd8, 32'h0000_00FF);
    apb(OFF_ID, 1'b0, 32'h0, rd, rd8, er);
    check("id16", rd,  32'h6770_0010);
    check("id8",  rd8, 32'h6770_0008);

    // ---- randomized traffic against the model
    for (int t = 0; t < 1200; t++) begin
      ss_ctrl_3 = ($urandom_range(0, 7) == 0) ? (8'($urandom) & 8'hFE) : (8'($urandom) | 8'h01);
      irq_en_3  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) pmod_gpi = pmod_gpi ^ 16'($urandom & $urandom);
      off = 3'($urandom_range(0, 7));
      low = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      apb(32'({off, low}), 1'($urandom), $urandom, rd, rd8, er);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk_in);
    end

    repeat (2) @(negedge clk_in);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ss_apb_gpio.md
SS_APB_GPIO -- requirements
Module: ss_apb_gpio

Interface
REQ-001 SHALL have parameter GPIO_W, default 16, number of pmod GPIO lines (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..4).
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_int  input  1  synchronous active-high reset.
REQ-005 SHALL have ports PADDR input 32, PENABLE input 1, PSEL input 1, PWDATA input 32, PWRITE input 1: APB slave request.
REQ-006 SHALL have ports PRDATA output 32, PREADY output 1, PSLVERR output 1: APB slave response.
REQ-007 SHALL have port irq_3  output 1  level interrupt to the SoC.
REQ-008 SHALL have port irq_en_3  input 1  SoC-side interrupt mask.
REQ-009 SHALL have port ss_ctrl_3  input 8  subsystem control; bit0 = subsystem enable; bits 7:1 ignored.
REQ-010 SHALL have ports pmod_gpi input GPIO_W, pmod_gpo output GPIO_W, pmod_gpio_oe output GPIO_W.

Function
REQ-011 SHALL decode registers on PADDR[4:2]: 0 DOUT (RW), 1 DIR (RW, 1=output), 2 DIN (RO), 3 RISE_EN (RW), 4 FALL_EN (RW), 5 STATUS (RO, W1C), 6 ID (RO, constant 0x6770_0000 | GPIO_W); offsets 7 and PADDR[1:0]!=0 unmapped.
REQ-012 SHALL complete every transfer with zero wait states: PREADY=1 exactly in cycles where PSEL&PENABLE, else 0.
REQ-013 SHALL perform register writes in the access cycle (PSEL&PENABLE&PWRITE&PREADY); write effect visible on the next cycle.
REQ-014 SHALL drive PRDATA combinationally in the access cycle, zero-extended from GPIO_W; PRDATA=0 outside access cycles and for writes.
REQ-015 SHALL assert PSLVERR with PREADY for unmapped offsets, writes to DIN or ID, and any access while ss_ctrl_3[0]=0; errored writes SHALL have no effect.
REQ-016 SHALL ignore PWDATA bits at and above GPIO_W.
REQ-017 SHALL pass pmod_gpi through SYNC_STAGES flops; DIN reads the synchroniser output.
REQ-018 SHALL register one further copy of DIN; rising edge = DIN&~prev, falling edge = ~DIN&prev, per bit.
REQ-019 SHALL set STATUS[i] on the cycle after a qualified edge (rising&RISE_EN[i] or falling&FALL_EN[i]); bits stay set until cleared.
REQ-020 SHALL clear STATUS bits written 1 to STATUS; on the same cycle as a new edge on that bit, set SHALL win.
REQ-021 SHALL drive irq_3 registered = irq_en_3 & ss_ctrl_3[0] & |(STATUS & (RISE_EN|FALL_EN)); one-cycle latency from STATUS change.
REQ-022 SHALL drive pmod_gpo = DOUT & DIR and pmod_gpio_oe = DIR when ss_ctrl_3[0]=1; both all-zero when ss_ctrl_3[0]=0, registers retained.
REQ-023 SHALL not detect edges while ss_ctrl_3[0]=0; prev copy still tracks DIN so re-enable does not produce spurious edges.

Reset
REQ-024 SHALL on reset_int clear DOUT, DIR, RISE_EN, FALL_EN, STATUS, synchroniser and prev flops, and irq_3 to 0.
REQ-025 SHALL hold PREADY, PSLVERR, PRDATA at 0 while reset_int=1, including reset asserted mid-transfer; that transfer SHALL have no effect.
REQ-026 SHALL not produce edges in the first SYNC_STAGES+1 cycles after reset release from pmod_gpi held constant high (prev initialised 0 rises once, then masked because RISE_EN=0 after reset).

Structure
REQ-027 SHALL place register offset constants, ID constant and the register-index enum in package ss_apb_gpio_pkg.
REQ-028 SHALL implement the input synchroniser as sub-module ss_gpio_sync (parameters WIDTH, STAGES); all else in ss_apb_gpio.
REQ-029 SHALL be 120-400 lines of RTL total, no latches, no clock gating.

Verification
REQ-030 Write DIR=0x00FF, DOUT=0xA5A5, ss_ctrl_3=0x01 -> pmod_gpo=0x00A5, pmod_gpio_oe=0x00FF; ss_ctrl_3=0x00 -> both 0x0000, PSLVERR=1 on next access.
REQ-031 RISE_EN=0x0001, irq_en_3=1, pmod_gpi[0] 0->1 -> STATUS=0x0001 at cycle SYNC_STAGES+2, irq_3=1 one cycle later; write STATUS=0x0001 -> irq_3=0 two cycles later.
REQ-032 FALL_EN=0x8000, pmod_gpi[15] 1->0 timed so edge set coincides with W1C write of 0x8000 -> STATUS[15] stays 1.
REQ-033 Read PADDR 0x1C, write PADDR 0x08, read PADDR 0x02 -> PSLVERR=1, PREADY=1 each, DIN unchanged; read ID -> 0x6770_0010.
REQ-034 Assert reset_int during access phase of write DOUT=0xFFFF -> PREADY=0, DOUT reads 0x0000 after release; repeat with GPIO_W=8 -> write 0xFFFF reads back 0x00FF.
